// File: rtl/inst_pkg.sv
// inst_pkg: shared state encoding, decoder field encodings and PC step for inst_sequencer
package inst_pkg;
    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM_WAIT,
        WB,
        BRANCH,
        TRAP
    } state_e;
    localparam logic [1:0] IT_DATA   = 2'b00;
    localparam logic [1:0] IT_MEM    = 2'b01;
    localparam logic [1:0] IT_BRANCH = 2'b10;
    localparam logic [1:0] MT_LOAD   = 2'b00;
    localparam logic [1:0] MT_STORE  = 2'b01;
    localparam logic [1:0] BT_JUMP   = 2'b00;
    localparam logic [1:0] BT_BEQ    = 2'b01;
    localparam logic [1:0] BT_BNE    = 2'b10;
    localparam logic [1:0] BT_RSVD   = 2'b11;
    localparam int PC_INC = 4;
endpackage

// File: rtl/seq_wait_counter.sv
// seq_wait_counter: loadable down-counter whose done flag marks the last cycle of a wait
module seq_wait_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;
    // load has priority; decrement stops at zero
    always_comb begin
        cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end
    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign done = (cnt_q == '0);
endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: multi-cycle decode/exec/mem/branch sequencer; INST_SEQ_PERF_EN adds retire/stall counters
module inst_sequencer
    import inst_pkg::*;
#(
    parameter int unsigned     PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     ALU_LAT     = 2,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
`ifdef INST_SEQ_PERF_EN
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt,
`endif
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic            inst_ready,
    output logic [31:0]     ir_out,
    input  logic [1:0]      instype,
    input  logic [2:0]      datainstype,
    input  logic [1:0]      meminstype,
    input  logic [1:0]      branchinstype,
    input  logic            branch_eq,
    input  logic [PC_W-1:0] branch_target,
    input  logic            mem_ack,
    output logic            alu_start,
    output logic [2:0]      alu_op,
    output logic            mem_req,
    output logic            mem_we,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            trap
);
    localparam int unsigned AW = $clog2(ALU_LAT + 1);
    localparam int unsigned MW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [1:0]      br_q, br_d;
    logic            is_store_q, is_store_d;
    logic            inst_ready_q, inst_ready_d;
    logic            alu_start_q, alu_start_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            reg_we_q, reg_we_d;
    logic            retire_q, retire_d;
    logic            trap_q, trap_d;
    logic            alu_load, alu_done, mem_load, mem_done, taken;

    seq_wait_counter #(.W(AW)) u_alu_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (alu_load),
        .load_val (AW'(ALU_LAT - 1)),
        .dec      (state_q == EXEC),
        .done     (alu_done)
    );

    seq_wait_counter #(.W(MW)) u_mem_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (mem_load),
        .load_val (MW'(MEM_TIMEOUT - 1)),
        .dec      (state_q == MEM_WAIT),
        .done     (mem_done)
    );

    assign pc_inc = pc_q + PC_W'(PC_INC);
    assign taken  = (br_q == BT_JUMP) || (br_q == BT_BEQ && branch_eq) || (br_q == BT_BNE && !branch_eq);

    // next state and next registered outputs; every output is set on the edge entering the cycle it marks
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        pc_d         = pc_q;
        alu_op_d     = alu_op_q;
        br_d         = br_q;
        is_store_d   = is_store_q;
        inst_ready_d = 1'b0;
        alu_start_d  = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        reg_we_d     = 1'b0;
        retire_d     = 1'b0;
        trap_d       = 1'b0;
        alu_load     = 1'b0;
        mem_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    ir_d    = inst;
                    state_d = DECODE;
                end else begin
                    inst_ready_d = 1'b1;
                end
            end
            DECODE: begin
                alu_op_d   = datainstype;
                br_d       = branchinstype;
                is_store_d = (meminstype == MT_STORE);
                if (instype == IT_DATA) begin
                    state_d     = EXEC;
                    alu_start_d = 1'b1;
                    alu_load    = 1'b1;
                end else if (instype == IT_MEM && !meminstype[1]) begin
                    state_d   = MEM_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = (meminstype == MT_STORE);
                    mem_load  = 1'b1;
                end else if (instype == IT_BRANCH && branchinstype != BT_RSVD) begin
                    state_d = BRANCH;
                end else begin
                    state_d = TRAP;
                end
            end
            EXEC: begin
                state_d = alu_done ? WB : EXEC;
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d      = is_store_q ? IDLE : WB;
                    retire_d     = is_store_q;
                    inst_ready_d = is_store_q;
                    pc_d         = is_store_q ? pc_inc : pc_q;
                end else if (mem_done) begin
                    state_d = TRAP;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = is_store_q;
                end
            end
            WB: begin
                state_d      = IDLE;
                reg_we_d     = 1'b1;
                retire_d     = 1'b1;
                inst_ready_d = 1'b1;
                pc_d         = pc_inc;
            end
            BRANCH: begin
                state_d      = IDLE;
                retire_d     = 1'b1;
                inst_ready_d = 1'b1;
                pc_d         = taken ? branch_target : pc_inc;
            end
            TRAP: begin
                state_d      = IDLE;
                trap_d       = 1'b1;
                inst_ready_d = 1'b1;
            end
            default: begin
                state_d      = IDLE;
                inst_ready_d = 1'b1;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_q         <= '0;
            pc_q         <= RESET_PC;
            alu_op_q     <= '0;
            br_q         <= '0;
            is_store_q   <= 1'b0;
            inst_ready_q <= 1'b1;
            alu_start_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            pc_q         <= pc_d;
            alu_op_q     <= alu_op_d;
            br_q         <= br_d;
            is_store_q   <= is_store_d;
            inst_ready_q <= inst_ready_d;
            alu_start_q  <= alu_start_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            reg_we_q     <= reg_we_d;
            retire_q     <= retire_d;
            trap_q       <= trap_d;
        end
    end

    assign inst_ready = inst_ready_q;
    assign ir_out     = ir_q;
    assign pc         = pc_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = alu_start_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign reg_we     = reg_we_q;
    assign retire     = retire_q;
    assign trap       = trap_q;

`ifdef INST_SEQ_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d, stall_cnt_q, stall_cnt_d;
    // saturating counters: retirements and memory cycles spent without an ack
    always_comb begin
        retired_cnt_d = (retire_d && retired_cnt_q != '1) ? retired_cnt_q + 32'd1 : retired_cnt_q;
        stall_cnt_d   = (state_q == MEM_WAIT && !mem_ack && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end
    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: scoreboard bench for inst_sequencer; stimulus pushes expectations, monitor checks each retire/trap
module tb_inst_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready;
    logic [31:0] ir_out;
    logic [1:0]  instype = '0;
    logic [2:0]  datainstype = '0;
    logic [1:0]  meminstype = '0;
    logic [1:0]  branchinstype = '0;
    logic        branch_eq = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_ack = 1'b0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [31:0] pc;
    logic        retire;
    logic        trap;
`ifdef INST_SEQ_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    inst_sequencer dut (
        .clk           (clk),
        .rst           (rst),
`ifdef INST_SEQ_PERF_EN
        .retired_cnt   (retired_cnt),
        .stall_cnt     (stall_cnt),
`endif
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_ready    (inst_ready),
        .ir_out        (ir_out),
        .instype       (instype),
        .datainstype   (datainstype),
        .meminstype    (meminstype),
        .branchinstype (branchinstype),
        .branch_eq     (branch_eq),
        .branch_target (branch_target),
        .mem_ack       (mem_ack),
        .alu_start     (alu_start),
        .alu_op        (alu_op),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .reg_we        (reg_we),
        .pc            (pc),
        .retire        (retire),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        trap;
        logic [31:0] pc;
        logic        we;
        int          lat;
        int          nalu;
        int          nmreq;
        int          nmwe;
        logic [2:0]  op;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   nacc = 0;
    int   nalu = 0;
    int   nmreq = 0;
    int   nmwe = 0;
    int   inst_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // monitor: pops one expectation per retire/trap and tracks strobes since the last accept
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            nalu  += int'(alu_start);
            nmreq += int'(mem_req);
            nmwe  += int'(mem_we);
            if (retire || trap) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output retire=%0b trap=%0b expected=none", retire, trap);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, ".trap"}, 32'(trap), 32'(e.trap));
                    chk({e.name, ".retire"}, 32'(retire), 32'(!e.trap));
                    chk({e.name, ".pc"}, pc, e.pc);
                    chk({e.name, ".reg_we"}, 32'(reg_we), 32'(e.we));
                    chk({e.name, ".latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
                    chk({e.name, ".alu_starts"}, 32'(nalu), 32'(e.nalu));
                    chk({e.name, ".mem_req_cycles"}, 32'(nmreq), 32'(e.nmreq));
                    chk({e.name, ".mem_we_cycles"}, 32'(nmwe), 32'(e.nmwe));
                    chk({e.name, ".ir_out"}, ir_out, e.ir);
                    if (e.nalu > 0) chk({e.name, ".alu_op"}, 32'(alu_op), 32'(e.op));
                end
            end
            if (inst_valid && inst_ready) begin
                acc_cyc = cyc;
                nacc++;
                nalu  = 0;
                nmreq = 0;
                nmwe  = 0;
            end
        end
    end

    task automatic set_fields(input logic [1:0] it, input logic [2:0] dt, input logic [1:0] mt, input logic [1:0] bt, input logic eq, input logic [31:0] tgt);
        inst_n++;
        inst          = 32'hA500_0000 + 32'(inst_n);
        instype       = it;
        datainstype   = dt;
        meminstype    = mt;
        branchinstype = bt;
        branch_eq     = eq;
        branch_target = tgt;
    endtask

    task automatic push(input string name, input logic etrap, input logic [31:0] epc, input logic ewe, input int elat, input int ealu, input int emreq, input int emwe);
        exp_t e;
        e.name  = name;
        e.trap  = etrap;
        e.pc    = epc;
        e.we    = ewe;
        e.lat   = elat;
        e.nalu  = ealu;
        e.nmreq = emreq;
        e.nmwe  = emwe;
        e.op    = datainstype;
        e.ir    = inst;
        sb.push_back(e);
    endtask

    task automatic issue(input string name, input logic [1:0] it, input logic [2:0] dt, input logic [1:0] mt, input logic [1:0] bt, input logic eq, input logic [31:0] tgt, input int ack_k, input logic etrap, input logic [31:0] epc, input logic ewe, input int elat, input int ealu, input int emreq, input int emwe);
        int t;
        int seen;
        set_fields(it, dt, mt, bt, eq, tgt);
        push(name, etrap, epc, ewe, elat, ealu, emreq, emwe);
        inst_valid = 1'b1;
        t = 0;
        while (!inst_ready && t < 40) begin
            step;
            t++;
        end
        if (!inst_ready) begin
            checks++;
            errors++;
            $display("FAIL %s.accept timeout inst_ready=0 expected=1", name);
        end
        step;
        inst_valid = 1'b0;
        if (ack_k > 0) begin
            seen = 0;
            t = 0;
            while (t < 40) begin
                if (mem_req) begin
                    seen++;
                    if (seen == ack_k) begin
                        mem_ack = 1'b1;
                        step;
                        mem_ack = 1'b0;
                        break;
                    end
                end
                step;
                t++;
            end
        end
        t = 0;
        while (!(retire || trap) && t < 40) begin
            step;
            t++;
        end
        if (!(retire || trap)) begin
            checks++;
            errors++;
            $display("FAIL %s.done timeout retire=0 trap=0 expected=pulse", name);
        end
    endtask

    initial begin
        int t;
        int rets;
        int acc0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.pc", pc, 32'h0);
        chk("reset.inst_ready", 32'(inst_ready), 32'd1);
        chk("reset.ir_out", ir_out, 32'h0);
        chk("reset.outs", {26'd0, alu_start, mem_req, mem_we, reg_we, retire, trap}, 32'h0);
        chk("reset.alu_op", 32'(alu_op), 32'h0);

        //     name          it     dt      mt     bt     eq    target        ack trap pc            we lat alu mreq mwe
        issue("data",        2'b00, 3'b101, 2'b00, 2'b00, 1'b0, 32'h0,        0,  0, 32'h4,        1, 5,  1,  0,  0);
        issue("load3",       2'b01, 3'b000, 2'b00, 2'b00, 1'b0, 32'h0,        3,  0, 32'h8,        1, 6,  0,  3,  0);
        issue("store3",      2'b01, 3'b000, 2'b01, 2'b00, 1'b0, 32'h0,        3,  0, 32'hC,        0, 5,  0,  3,  3);
        issue("beq_taken",   2'b10, 3'b000, 2'b00, 2'b01, 1'b1, 32'h100,      0,  0, 32'h100,      0, 3,  0,  0,  0);
        issue("bne_nottkn",  2'b10, 3'b000, 2'b00, 2'b10, 1'b1, 32'h200,      0,  0, 32'h104,      0, 3,  0,  0,  0);
        issue("bne_taken",   2'b10, 3'b000, 2'b00, 2'b10, 1'b0, 32'h80,       0,  0, 32'h80,       0, 3,  0,  0,  0);
        issue("jump",        2'b10, 3'b000, 2'b00, 2'b00, 1'b0, 32'h40,       0,  0, 32'h40,       0, 3,  0,  0,  0);
        issue("rsvd_type",   2'b11, 3'b000, 2'b00, 2'b00, 1'b0, 32'h0,        0,  1, 32'h40,       0, 3,  0,  0,  0);
        issue("rsvd_branch", 2'b10, 3'b000, 2'b00, 2'b11, 1'b1, 32'h300,      0,  1, 32'h40,       0, 3,  0,  0,  0);
        issue("rsvd_mem",    2'b01, 3'b000, 2'b10, 2'b00, 1'b0, 32'h0,        0,  1, 32'h40,       0, 3,  0,  0,  0);
        issue("mem_timeout", 2'b01, 3'b000, 2'b00, 2'b00, 1'b0, 32'h0,        0,  1, 32'h40,       0, 18, 0,  15, 0);
        issue("ack_on_15",   2'b01, 3'b000, 2'b01, 2'b00, 1'b0, 32'h0,        15, 0, 32'h44,       0, 17, 0,  15, 15);
        issue("load1",       2'b01, 3'b000, 2'b00, 2'b00, 1'b0, 32'h0,        1,  0, 32'h48,       1, 4,  0,  1,  0);
        issue("jump_top",    2'b10, 3'b000, 2'b00, 2'b00, 1'b0, 32'hFFFFFFFC, 0,  0, 32'hFFFFFFFC, 0, 3,  0,  0,  0);
        issue("pc_wrap",     2'b00, 3'b010, 2'b00, 2'b00, 1'b0, 32'h0,        0,  0, 32'h0,        1, 5,  1,  0,  0);
        chk("after_trap.inst_ready", 32'(inst_ready), 32'd1);

        // abort a data instruction in its first EXEC cycle; nothing is expected from it
        set_fields(2'b00, 3'b111, 2'b00, 2'b00, 1'b0, 32'h0);
        inst_valid = 1'b1;
        step;
        inst_valid = 1'b0;
        step;
        chk("abort.alu_start", 32'(alu_start), 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort.pc", pc, 32'h0);
        chk("abort.inst_ready", 32'(inst_ready), 32'd1);
        chk("abort.alu_start_cleared", 32'(alu_start), 32'd0);
        repeat (8) step;

        // inst_valid held high: three data instructions back to back
        set_fields(2'b00, 3'b011, 2'b00, 2'b00, 1'b0, 32'h0);
        push("b2b_0", 0, 32'h4, 1, 5, 1, 0, 0);
        push("b2b_1", 0, 32'h8, 1, 5, 1, 0, 0);
        push("b2b_2", 0, 32'hC, 1, 5, 1, 0, 0);
        acc0 = nacc;
        inst_valid = 1'b1;
        rets = 0;
        t = 0;
        while (rets < 3 && t < 60) begin
            step;
            t++;
            if (retire) rets++;
        end
        inst_valid = 1'b0;
        chk("b2b.retires", 32'(rets), 32'd3);
        repeat (6) step;
        chk("b2b.accepts", 32'(nacc - acc0), 32'd3);
        chk("end.scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
